// File: rtl/ks_subtractor_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ks_subtractor_pipe
//  Brief    : Three-stage pipelined Kogge-Stone subtractor computing a - b
//             with valid/ready handshakes on both sides. Reports the unsigned
//             borrow (inverted carry-out) and the signed overflow.
//             Optional macro KS_SUB_SAT_EN: unsigned saturation, so diff is
//             forced to 0 whenever borrow is set.
//  Revision : 1.0 - initial release
// ============================================================================
module ks_subtractor_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int LEVELS    = $clog2(WIDTH);
  localparam int S2_LEVELS = (LEVELS + 1) / 2;

  // S1: operand capture with per-bit propagate/generate
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s1_a_msb_q, s1_a_msb_d;
  logic             s1_b_msb_q, s1_b_msb_d;

  // S2: first half of the prefix tree; raw propagate kept for the sum XOR
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_p_q, s2_p_d;
  logic [WIDTH-1:0] s2_gg_q, s2_gg_d;
  logic [WIDTH-1:0] s2_gp_q, s2_gp_d;
  logic             s2_a_msb_q, s2_a_msb_d;
  logic             s2_b_msb_q, s2_b_msb_d;

  // S3: output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Combinational intermediates
  logic             advance;
  logic [WIDTH-1:0] pre_p, pre_g;
  logic [WIDTH-1:0] lo_gg, lo_gp, lo_gg_prev, lo_gp_prev;
  logic [WIDTH-1:0] hi_gg, hi_gp, hi_gg_prev, hi_gp_prev;
  logic [WIDTH-1:0] diff_raw;
  logic             borrow_raw;
  logic             ovf_raw;

  // Whole pipe moves together; stalls only when the held result is refused.
  // The out_ready -> in_ready combinational path is deliberate.
  assign advance  = ~(out_valid_q & ~out_ready);
  assign in_ready = advance;

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

  // Pre-processing over a and ~b; carry-in of 1 is folded into bit-0 generate
  always_comb begin
    pre_p    = a ^ ~b;
    pre_g    = a & ~b;
    pre_g[0] = a[0] | ~b[0];
  end

  // Lower prefix levels (spans 1, 2, ...) evaluated on the S1 register
  always_comb begin
    lo_gg      = s1_g_q;
    lo_gp      = s1_p_q;
    lo_gg_prev = '0;
    lo_gp_prev = '0;
    for (int k = 0; k < S2_LEVELS; k++) begin
      lo_gg_prev = lo_gg;
      lo_gp_prev = lo_gp;
      for (int i = (1 << k); i < WIDTH; i++) begin
        lo_gg[i] = lo_gg_prev[i] | (lo_gp_prev[i] & lo_gg_prev[i - (1 << k)]);
        lo_gp[i] = lo_gp_prev[i] & lo_gp_prev[i - (1 << k)];
      end
    end
  end

  // Upper prefix levels on the S2 register, then the sum/borrow/overflow
  always_comb begin
    hi_gg      = s2_gg_q;
    hi_gp      = s2_gp_q;
    hi_gg_prev = '0;
    hi_gp_prev = '0;
    for (int k = S2_LEVELS; k < LEVELS; k++) begin
      hi_gg_prev = hi_gg;
      hi_gp_prev = hi_gp;
      for (int i = (1 << k); i < WIDTH; i++) begin
        hi_gg[i] = hi_gg_prev[i] | (hi_gp_prev[i] & hi_gg_prev[i - (1 << k)]);
        hi_gp[i] = hi_gp_prev[i] & hi_gp_prev[i - (1 << k)];
      end
    end
    // hi_gg[i] is now the carry out of bit i; bit 0 sees the carry-in of 1
    diff_raw   = s2_p_q ^ {hi_gg[WIDTH-2:0], 1'b1};
    borrow_raw = ~hi_gg[WIDTH-1];
    ovf_raw    = (s2_a_msb_q ^ s2_b_msb_q) & (diff_raw[WIDTH-1] ^ s2_a_msb_q);
  end

  // Next-state for every stage: hold by default, shift forward on advance
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_p_d      = s1_p_q;
    s1_g_d      = s1_g_q;
    s1_a_msb_d  = s1_a_msb_q;
    s1_b_msb_d  = s1_b_msb_q;
    s2_valid_d  = s2_valid_q;
    s2_p_d      = s2_p_q;
    s2_gg_d     = s2_gg_q;
    s2_gp_d     = s2_gp_q;
    s2_a_msb_d  = s2_a_msb_q;
    s2_b_msb_d  = s2_b_msb_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_p_d      = pre_p;
      s1_g_d      = pre_g;
      s1_a_msb_d  = a[WIDTH-1];
      s1_b_msb_d  = b[WIDTH-1];
      s2_valid_d  = s1_valid_q;
      s2_p_d      = s1_p_q;
      s2_gg_d     = lo_gg;
      s2_gp_d     = lo_gp;
      s2_a_msb_d  = s1_a_msb_q;
      s2_b_msb_d  = s1_b_msb_q;
      out_valid_d = s2_valid_q;
`ifdef KS_SUB_SAT_EN
      diff_d      = borrow_raw ? '0 : diff_raw;
`else
      diff_d      = diff_raw;
`endif
      borrow_d    = borrow_raw;
      ovf_d       = ovf_raw;
    end
  end

  // Pipeline registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_a_msb_q  <= 1'b0;
      s1_b_msb_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      s2_gg_q     <= '0;
      s2_gp_q     <= '0;
      s2_a_msb_q  <= 1'b0;
      s2_b_msb_q  <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_a_msb_q  <= s1_a_msb_d;
      s1_b_msb_q  <= s1_b_msb_d;
      s2_valid_q  <= s2_valid_d;
      s2_p_q      <= s2_p_d;
      s2_gg_q     <= s2_gg_d;
      s2_gp_q     <= s2_gp_d;
      s2_a_msb_q  <= s2_a_msb_d;
      s2_b_msb_q  <= s2_b_msb_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule
`default_nettype wire
